// File: rtl/sha3_scan_job_issuer.sv
// Scan job issuer: latches one host job, starts the sha3 scanner (re-pulsing start when it is ignored),
// follows it to completion and queues every found result in a small FIFO for the host to drain.
module sha3_scan_job_issuer #(
   parameter int PROPER        = 1,
   parameter int FIFO_DEPTH    = 4,
   parameter int HASH_KEEP     = 4,
   parameter int START_TIMEOUT = 16,
   localparam int TWORDS       = (PROPER != 0) ? 20 : 24
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        job_valid,
   output logic                        job_ready,
   input  logic [63:0]                 job_threshold,
   input  logic [TWORDS-1:0][31:0]     job_template,
   output logic                        sc_start,
   output logic [63:0]                 sc_threshold,
   output logic [TWORDS-1:0][31:0]     sc_template,
   input  logic                        sc_found,
   input  logic [24:0][63:0]           sc_hash,
   input  logic [31:0]                 sc_nonce,
   input  logic                        sc_dispatching,
   input  logic                        sc_evaluating,
   input  logic                        sc_ready,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [31:0]                 res_nonce,
   output logic [HASH_KEEP-1:0][63:0]  res_hash,
   output logic                        busy,
   output logic [31:0]                 jobs_done,
   output logic [31:0]                 found_total,
   output logic [15:0]                 dropped,
   output logic [7:0]                  retries
);

   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int TIMER_W = $clog2(START_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, ARM, START, CONFIRM, RUN, DONE} state_t;

   typedef struct packed {
      logic [31:0]                nonce;
      logic [HASH_KEEP-1:0][63:0] hash;
   } entry_t;

   state_t               state;
   state_t               next_state;
   logic [TIMER_W-1:0]   timer;
   logic                 accept;
   logic                 timeout;

   entry_t               mem [FIFO_DEPTH];
   logic [AW:0]          wr_ptr;
   logic [AW:0]          rd_ptr;
   logic [AW:0]          count;
   logic                 full;
   logic                 empty;
   logic                 pop;
   logic                 push;
   logic                 drop;
   logic                 unused_hash;

   // Gated by rst_n so the whole output set reads zero while reset is held.
   assign job_ready = (state == IDLE) && rst_n;
   assign busy      = (state != IDLE);
   assign sc_start  = (state == START);
   assign accept    = job_valid && job_ready;
   assign timeout   = (state == CONFIRM) && !sc_dispatching &&
                      (timer == TIMER_W'(START_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = ARM;
         ARM:     if (sc_ready) next_state = START;
         START:   next_state = CONFIRM;
         CONFIRM: begin
            if (sc_dispatching) next_state = RUN;
            else if (timeout)   next_state = ARM;
         end
         RUN:     if (sc_ready && !sc_dispatching && !sc_evaluating) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // The timer only runs while waiting for the scanner to confirm the start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= '0;
      end else if (state == CONFIRM) begin
         timer <= timer + 1'b1;
      end else begin
         timer <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sc_threshold <= '0;
         sc_template  <= '0;
         jobs_done    <= '0;
         retries      <= '0;
      end else begin
         if (accept) begin
            sc_threshold <= job_threshold;
            sc_template  <= job_template;
         end
         if (timeout && (retries != 8'hFF)) retries <= retries + 8'd1;
         if (state == DONE) jobs_done <= jobs_done + 32'd1;
      end
   end

   assign count       = wr_ptr - rd_ptr;
   assign empty       = (wr_ptr == rd_ptr);
   assign full        = (count == (AW+1)'(FIFO_DEPTH));
   assign pop         = !empty && res_ready;
   assign push        = sc_found && (!full || pop);
   assign drop        = sc_found && full && !pop;
   assign unused_hash = ^sc_hash;

   // A push into a full FIFO that is popped in the same cycle overwrites the slot being read out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]].nonce <= sc_nonce;
            mem[wr_ptr[AW-1:0]].hash  <= sc_hash[HASH_KEEP-1:0];
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         found_total <= '0;
         dropped     <= '0;
      end else begin
         if (sc_found && (found_total != 32'hFFFF_FFFF)) found_total <= found_total + 32'd1;
         if (drop && (dropped != 16'hFFFF)) dropped <= dropped + 16'd1;
      end
   end

   assign res_valid = !empty;
   assign res_nonce = mem[rd_ptr[AW-1:0]].nonce;
   assign res_hash  = mem[rd_ptr[AW-1:0]].hash;

endmodule
